// File: rtl/lpm_mult_ctrl_pkg.sv
// Shared definitions for the lpm_mult arbiter: FSM encoding and sizing helpers.
package lpm_mult_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_e;

  localparam int DEFAULT_LAT = 2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction

  // Stage 0 is the operand register, followed by one stage per multiplier clock.
  function automatic int tag_depth(input int lat);
    return ((lat > 0) ? lat : 0) + 1;
  endfunction

  localparam int DEFAULT_TAG_DEPTH = tag_depth(DEFAULT_LAT);

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester selection; pointer advances past the winner on each accepted grant.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic            clock,
  input  logic            aclr,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  winner,
  output logic            fire
);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic           found;
  int             idx;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
    fire        = found & en;
    gnt         = '0;
    gnt[winner] = fire;
    ptr_d       = ptr_q;
    if (fire)
      ptr_d = (int'(winner) == NREQ - 1) ? '0 : winner + IDW'(1);
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end

endmodule

// File: rtl/lpm_mult_arbiter.sv
// Shares one pipelined lpm_mult between NREQ requesters; a tag pipe aligned to the
// multiplier latency returns each product with its requester ID. Supports drain/halt.
module lpm_mult_arbiter
  import lpm_mult_ctrl_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int WA   = 16,
  parameter int WB   = 16,
  parameter int WP   = 32,
  parameter int LAT  = 2,
  parameter int IDW  = 2
) (
  input  logic               clock,
  input  logic               aclr,
  input  logic               clken,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*WA-1:0] dataa_bus,
  input  logic [NREQ*WB-1:0] datab_bus,
  output logic [NREQ-1:0]    gnt,
  input  logic               drain_req,
  output logic               idle,
  output logic [WA-1:0]      mult_dataa,
  output logic [WB-1:0]      mult_datab,
  output logic               mult_clken,
  input  logic [WP-1:0]      mult_result,
  output logic               rsp_valid,
  output logic [IDW-1:0]     rsp_id,
  output logic [WP-1:0]      rsp_result
);

  localparam int D = tag_depth(LAT);

  if (IDW < clog2(NREQ)) begin : g_bad_idw
    $error("IDW too narrow for NREQ");
  end

  state_e                  state_q, state_d;
  logic                    issue_en, fire;
  logic [IDW-1:0]          winner;
  logic [WA-1:0]           dataa_q, dataa_d;
  logic [WB-1:0]           datab_q, datab_d;
  logic [D-1:0]            tvld_q, tvld_d;
  logic [D-1:0][IDW-1:0]   tid_q, tid_d;

  // Drain suppresses the grant in the very cycle it rises, hence the direct term.
  assign issue_en = clken & ~aclr & ~drain_req & (state_q == RUN);

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .clock  (clock),
    .aclr   (aclr),
    .en     (issue_en),
    .req    (req),
    .gnt    (gnt),
    .winner (winner),
    .fire   (fire)
  );

  always_comb begin
    dataa_d = dataa_q;
    datab_d = datab_q;
    tvld_d  = tvld_q;
    tid_d   = tid_q;
    if (clken) begin
      if (fire) begin
        dataa_d = dataa_bus[winner*WA +: WA];
        datab_d = datab_bus[winner*WB +: WB];
      end
      for (int s = D - 1; s > 0; s--) begin
        tvld_d[s] = tvld_q[s-1];
        tid_d[s]  = tid_q[s-1];
      end
      tvld_d[0] = fire;
      tid_d[0]  = winner;
    end
  end

  // HALT is entered once the pipe is empty after this edge, so idle follows the last product.
  always_comb begin
    state_d = state_q;
    if (clken) begin
      case (state_q)
        RUN:     if (drain_req)  state_d = DRAIN;
        DRAIN:   if (~|tvld_d)   state_d = HALT;
        HALT:    if (!drain_req) state_d = RUN;
        default:                 state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      state_q <= RUN;
      dataa_q <= '0;
      datab_q <= '0;
      tvld_q  <= '0;
      tid_q   <= '0;
    end else begin
      state_q <= state_d;
      dataa_q <= dataa_d;
      datab_q <= datab_d;
      tvld_q  <= tvld_d;
      tid_q   <= tid_d;
    end
  end

  assign mult_dataa = dataa_q;
  assign mult_datab = datab_q;
  assign mult_clken = clken;
  assign rsp_valid  = tvld_q[D-1] & clken;
  assign rsp_id     = tid_q[D-1];
  assign rsp_result = mult_result;
  assign idle       = (state_q == HALT);

endmodule

// File: tb/tb_lpm_mult_arbiter.sv
// Directed bench for lpm_mult_arbiter with a behavioural 2-stage multiplier and a product scoreboard.
module tb_lpm_mult_arbiter;

  localparam int NREQ = 4, WA = 16, WB = 16, WP = 32, LAT = 2, IDW = 2;

  logic              clock = 1'b0;
  logic              aclr, clken, drain_req;
  logic [NREQ-1:0]   req;
  logic [NREQ*WA-1:0] dataa_bus;
  logic [NREQ*WB-1:0] datab_bus;
  logic [NREQ-1:0]   gnt;
  logic              idle, mult_clken, rsp_valid;
  logic [WA-1:0]     mult_dataa;
  logic [WB-1:0]     mult_datab;
  logic [WP-1:0]     mult_result, rsp_result;
  logic [IDW-1:0]    rsp_id;

  lpm_mult_arbiter #(.NREQ(NREQ), .WA(WA), .WB(WB), .WP(WP), .LAT(LAT), .IDW(IDW)) dut (
    .clock(clock), .aclr(aclr), .clken(clken), .req(req),
    .dataa_bus(dataa_bus), .datab_bus(datab_bus), .gnt(gnt),
    .drain_req(drain_req), .idle(idle),
    .mult_dataa(mult_dataa), .mult_datab(mult_datab), .mult_clken(mult_clken),
    .mult_result(mult_result), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_result(rsp_result)
  );

  initial forever #5 clock = ~clock;

  // Two-stage unsigned multiplier standing in for lpm_mult.
  logic [WP-1:0] mp0, mp1;
  always @(posedge clock)
    if (mult_clken) begin
      mp0 <= {16'd0, mult_dataa} * {16'd0, mult_datab};
      mp1 <= mp0;
    end
  assign mult_result = mp1;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [WP-1:0]  res;
  } exp_t;

  exp_t          exp_q[$];
  int            n_cmp, n_err;
  bit            cont;
  logic [NREQ-1:0] s_gnt;
  logic          s_rv, s_idle;
  logic [IDW-1:0] s_id;
  logic [WP-1:0] s_res;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input int i, input logic [15:0] a, input logic [15:0] b);
    dataa_bus[i*WA +: WA] = a;
    datab_bus[i*WB +: WB] = b;
  endtask

  // One clock: sample at negedge, score, then update requesters just after posedge.
  task automatic step();
    exp_t e;
    @(negedge clock);
    s_gnt = gnt; s_rv = rsp_valid; s_id = rsp_id; s_res = rsp_result; s_idle = idle;
    if (gnt != '0) begin
      chk("gnt_onehot", 32'($countones(gnt)), 32'd1);
      for (int i = 0; i < NREQ; i++)
        if (gnt[i]) begin
          e.id  = IDW'(i);
          e.res = {16'd0, dataa_bus[i*WA +: WA]} * {16'd0, datab_bus[i*WB +: WB]};
          exp_q.push_back(e);
        end
    end
    if (rsp_valid) begin
      if (exp_q.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("sb_id", 32'(rsp_id), 32'(e.id));
        chk("sb_result", rsp_result, e.res);
      end
    end
    @(posedge clock);
    #1;
    for (int i = 0; i < NREQ; i++)
      if (s_gnt[i]) begin
        if (cont) set_ops(i, 16'($urandom), 16'($urandom));
        else      req[i] = 1'b0;
      end
  endtask

  task automatic do_reset();
    aclr = 1'b1; req = '0; cont = 0; drain_req = 1'b0; clken = 1'b1;
    step();
    exp_q.delete();
    step();
    aclr = 1'b0;
  endtask

  task automatic flush(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    n_cmp = 0; n_err = 0; cont = 0;
    aclr = 1'b1; clken = 1'b1; drain_req = 1'b0; req = 4'b1111;
    dataa_bus = '0; datab_bus = '0;
    #2;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_rv", 32'(rsp_valid), 32'd0);
    chk("rst_idle", 32'(idle), 32'd0);
    chk("rst_ma", 32'(mult_dataa), 32'd0);
    chk("rst_mb", 32'(mult_datab), 32'd0);
    do_reset();

    // Single request on requester 2: 7*9 returns three cycles later.
    req = 4'b0100; set_ops(2, 16'd7, 16'd9);
    for (int k = 0; k < 7; k++) begin
      step();
      chk("t1_gnt", 32'(s_gnt), (k == 0) ? 32'h4 : 32'h0);
      chk("t1_rv", 32'(s_rv), 32'(k == 3));
      if (k == 3) begin
        chk("t1_id", 32'(s_id), 32'd2);
        chk("t1_res", s_res, 32'd63);
      end
    end

    // All requesters continuously from reset.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_ops(i, 16'($urandom), 16'($urandom));
    req = 4'b1111; cont = 1;
    for (int k = 0; k < 8; k++) begin
      step();
      if (k == 4) begin req = '0; cont = 0; end
      chk("t2_gnt", 32'(s_gnt), (k < 5) ? (32'd1 << (k % 4)) : 32'd0);
      chk("t2_rv", 32'(s_rv), 32'(k >= 3));
      if (k >= 3) chk("t2_id", 32'(s_id), 32'((k - 3) % 4));
    end
    flush(3);

    // Clock-enable stall of four cycles starting at cycle 2.
    do_reset();
    set_ops(0, 16'd3, 16'd4); set_ops(1, 16'd100, 16'd200); set_ops(2, 16'hffff, 16'hffff);
    req = 4'b0111;
    for (int k = 0; k < 12; k++) begin
      if (k == 2) clken = 1'b0;
      if (k == 6) clken = 1'b1;
      step();
      chk("t3_gnt", 32'(s_gnt), (k == 0) ? 32'h1 : (k == 1) ? 32'h2 : (k == 6) ? 32'h4 : 32'h0);
      chk("t3_rv", 32'(s_rv), 32'(k >= 7 && k <= 9));
      if (k >= 7 && k <= 9) chk("t3_id", 32'(s_id), 32'(k - 7));
    end

    // Drain with continuous traffic, then resume from the saved pointer.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_ops(i, 16'($urandom), 16'($urandom));
    req = 4'b1111; cont = 1;
    for (int k = 0; k < 13; k++) begin
      if (k == 5)  drain_req = 1'b1;
      if (k == 10) drain_req = 1'b0;
      step();
      chk("t4_gnt", 32'(s_gnt),
          (k < 5) ? (32'd1 << (k % 4)) : (k == 11) ? 32'h2 : (k == 12) ? 32'h4 : 32'h0);
      chk("t4_idle", 32'(s_idle), 32'(k >= 8 && k <= 10));
      chk("t4_rv", 32'(s_rv), 32'(k >= 3 && k <= 7));
    end
    req = '0; cont = 0;
    flush(5);

    // Reset with two products in flight.
    do_reset();
    set_ops(0, 16'd3, 16'd5); set_ops(1, 16'd11, 16'd13); set_ops(3, 16'd2, 16'd2);
    req = 4'b0011;
    step(); chk("t5_gnt0", 32'(s_gnt), 32'h1);
    step(); chk("t5_gnt1", 32'(s_gnt), 32'h2);
    req = 4'b1000; aclr = 1'b1;
    #1;
    chk("t5_rst_gnt", 32'(gnt), 32'd0);
    chk("t5_rst_rv", 32'(rsp_valid), 32'd0);
    chk("t5_rst_ma", 32'(mult_dataa), 32'd0);
    exp_q.delete();
    step(); step();
    aclr = 1'b0; req = '0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t5_no_rsp", 32'(s_rv), 32'd0);
    end
    set_ops(1, 16'd6, 16'd7);
    req = 4'b1010;
    step(); chk("t5_ptr0", 32'(s_gnt), 32'h2);
    step(); chk("t5_next", 32'(s_gnt), 32'h8);
    req = '0;
    flush(5);

    // Pointer at 3 with requesters 0 and 2: wraps to 0, skips to 2, wraps again.
    do_reset();
    set_ops(0, 16'd21, 16'd2); set_ops(2, 16'd5, 16'd5);
    req = 4'b0100;
    step(); chk("t6_gnt_a", 32'(s_gnt), 32'h4);
    req = 4'b0101; cont = 1;
    step(); chk("t6_gnt_b", 32'(s_gnt), 32'h1);
    step(); chk("t6_gnt_c", 32'(s_gnt), 32'h4);
    step(); chk("t6_gnt_d", 32'(s_gnt), 32'h1);
    req = '0; cont = 0;
    flush(5);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
